// File: rtl/io_pkg.sv
// Shared I/O address map constants and STAT register layout.
// Used by the output register block and the input side.
package io_pkg;

    localparam logic [5:0] PORT_BASE_DEF = 6'h20;
    localparam logic [5:0] STAT_OFS      = 6'd3;
    localparam int         VALID_LSB     = 0;
    localparam int         OVR_LSB       = 4;

    // Pack valid and overrun flags into the STAT read word.
    function automatic logic [31:0] stat_word(
        input logic [2:0] valid,
        input logic [2:0] ovr
    );
        logic [31:0] w;
        w = '0;
        w[VALID_LSB +: 3] = valid;
        w[OVR_LSB +: 3]   = ovr;
        return w;
    endfunction

endpackage

// File: rtl/io_output_mux.sv
// CPU readback selector for the output ports and STAT.
// Purely combinational; holds no state.
module io_output_mux
    import io_pkg::*;
#(
    parameter logic [5:0] PORT_BASE = PORT_BASE_DEF
) (
    input  logic [31:0] port0,
    input  logic [31:0] port1,
    input  logic [31:0] port2,
    input  logic [31:0] stat,
    input  logic [5:0]  sel,
    output logic [31:0] read_data
);

    logic [5:0] off;

    assign off = sel - PORT_BASE;

    // Select the register addressed by sel; unmapped reads return zero.
    always_comb begin
        read_data = '0;
        case (off)
            6'd0:     read_data = port0;
            6'd1:     read_data = port1;
            6'd2:     read_data = port2;
            STAT_OFS: read_data = stat;
            default:  read_data = '0;
        endcase
    end

endmodule

// File: rtl/io_output_reg.sv
// Memory-mapped CPU output ports with valid/ack handshake
// and sticky overrun flags, plus combinational readback.
module io_output_reg
    import io_pkg::*;
#(
    parameter int         NPORT     = 3,
    parameter logic [5:0] PORT_BASE = PORT_BASE_DEF
) (
    input  logic             io_clk,
    input  logic             resetn,
    input  logic [31:0]      addr,
    input  logic [31:0]      datain,
    input  logic             write_io_enable,
    output logic [31:0]      out_port0,
    output logic [31:0]      out_port1,
    output logic [31:0]      out_port2,
    output logic [NPORT-1:0] out_valid,
    input  logic [NPORT-1:0] out_ack,
    output logic [31:0]      io_read_data
);

    localparam logic [2:0] PMASK = 3'b111 >> (3 - NPORT);

    logic [31:0] port_q [3];
    logic [2:0]  valid_q;
    logic [2:0]  ovr_q;
    logic [2:0]  ack3;
    logic [2:0]  wr_port;
    logic        wr_stat;
    logic [5:0]  off;
    logic [2:0]  valid_n;
    logic [2:0]  ovr_n;
    logic [31:0] stat;

    assign off     = addr[7:2] - PORT_BASE;
    assign wr_stat = write_io_enable && (off == STAT_OFS);

    // Widen ack, decode port writes and compute next flag state.
    always_comb begin
        ack3    = '0;
        wr_port = '0;
        valid_n = valid_q;
        ovr_n   = ovr_q;
        for (int i = 0; i < NPORT; i++) begin
            ack3[i] = out_ack[i];
        end
        for (int i = 0; i < 3; i++) begin
            wr_port[i] = write_io_enable && PMASK[i]
                         && (off == 6'(i));
            if (wr_port[i]) begin
                valid_n[i] = 1'b1;
            end else if (ack3[i]) begin
                valid_n[i] = 1'b0;
            end
            if (wr_stat && datain[OVR_LSB + i]) begin
                ovr_n[i] = 1'b0;
            end
            if (wr_port[i] && valid_q[i] && !ack3[i]) begin
                ovr_n[i] = 1'b1;
            end
        end
        valid_n = valid_n & PMASK;
        ovr_n   = ovr_n & PMASK;
    end

    // Port data and flag registers; reset wins over writes and acks.
    always_ff @(posedge io_clk) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) begin
                port_q[i] <= '0;
            end
            valid_q <= '0;
            ovr_q   <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (wr_port[i]) begin
                    port_q[i] <= datain;
                end
            end
            valid_q <= valid_n;
            ovr_q   <= ovr_n;
        end
    end

    assign out_port0 = PMASK[0] ? port_q[0] : '0;
    assign out_port1 = PMASK[1] ? port_q[1] : '0;
    assign out_port2 = PMASK[2] ? port_q[2] : '0;
    assign out_valid = valid_q[NPORT-1:0];
    assign stat      = stat_word(valid_q, ovr_q);

    io_output_mux #(
        .PORT_BASE (PORT_BASE)
    ) u_mux (
        .port0     (out_port0),
        .port1     (out_port1),
        .port2     (out_port2),
        .stat      (stat),
        .sel       (addr[7:2]),
        .read_data (io_read_data)
    );

endmodule

// File: tb/tb_io_output_reg.sv
// Directed bench for io_output_reg with immediate-assertion checks.
// Expected values are hand-derived from the register behaviour.
module tb_io_output_reg;

    logic        io_clk;
    logic        resetn;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        write_io_enable;
    logic [31:0] out_port0;
    logic [31:0] out_port1;
    logic [31:0] out_port2;
    logic [2:0]  out_valid;
    logic [2:0]  out_ack;
    logic [31:0] io_read_data;

    int total = 0;
    int bad   = 0;

    io_output_reg dut (
        .io_clk          (io_clk),
        .resetn          (resetn),
        .addr            (addr),
        .datain          (datain),
        .write_io_enable (write_io_enable),
        .out_port0       (out_port0),
        .out_port1       (out_port1),
        .out_port2       (out_port2),
        .out_valid       (out_valid),
        .out_ack         (out_ack),
        .io_read_data    (io_read_data)
    );

    initial io_clk = 1'b0;
    always #5 io_clk = ~io_clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [31:0] a, input logic [31:0] d,
                       input logic we, input logic [2:0] ack);
        addr            = a;
        datain          = d;
        write_io_enable = we;
        out_ack         = ack;
        @(posedge io_clk);
        #1;
        write_io_enable = 1'b0;
        out_ack         = 3'b000;
        datain          = '0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, io_read_data, exp);
    endtask

    initial begin
        resetn          = 1'b0;
        addr            = '0;
        datain          = '0;
        write_io_enable = 1'b0;
        out_ack         = 3'b000;
        @(posedge io_clk);
        @(posedge io_clk);
        #1;
        resetn = 1'b1;
        cyc(32'h0, 32'h0, 1'b0, 3'b000);

        chk("rst_p0", out_port0, 32'h0);
        chk("rst_p1", out_port1, 32'h0);
        chk("rst_p2", out_port2, 32'h0);
        chk("rst_valid", {29'b0, out_valid}, 32'h0);
        rd("rst_stat", 32'h8C, 32'h0);

        cyc(32'h80, 32'h0000_03FF, 1'b1, 3'b000);
        chk("w0_p0", out_port0, 32'h3FF);
        chk("w0_valid", {29'b0, out_valid}, 32'h1);
        rd("w0_rd", 32'h80, 32'h3FF);
        cyc(32'h0, 32'h0, 1'b0, 3'b001);
        chk("ack0_valid", {29'b0, out_valid}, 32'h0);
        chk("ack0_hold", out_port0, 32'h3FF);

        cyc(32'h0, 32'h0, 1'b0, 3'b010);
        chk("ack_idle", {29'b0, out_valid}, 32'h0);

        cyc(32'h84, 32'hA5, 1'b1, 3'b000);
        cyc(32'h84, 32'h5A, 1'b1, 3'b000);
        chk("ovr_p1", out_port1, 32'h5A);
        rd("ovr_stat", 32'h8C, 32'h22);
        rd("ovr_rd1", 32'h84, 32'h5A);
        cyc(32'h8C, 32'h20, 1'b1, 3'b000);
        rd("w1c_stat", 32'h8C, 32'h02);

        cyc(32'h88, 32'h11, 1'b1, 3'b000);
        chk("w2_valid", {29'b0, out_valid}, 32'h6);
        cyc(32'h88, 32'h22, 1'b1, 3'b100);
        chk("wack_p2", out_port2, 32'h22);
        chk("wack_valid", {29'b0, out_valid}, 32'h6);
        rd("wack_stat", 32'h8C, 32'h06);

        resetn = 1'b0;
        cyc(32'h80, 32'hFFFF_FFFF, 1'b1, 3'b000);
        resetn = 1'b1;
        chk("rstw_p0", out_port0, 32'h0);
        chk("rstw_p2", out_port2, 32'h0);
        chk("rstw_valid", {29'b0, out_valid}, 32'h0);
        rd("rstw_stat", 32'h8C, 32'h0);

        cyc(32'h80, 32'h1234, 1'b1, 3'b000);
        cyc(32'h90, 32'hDEAD_BEEF, 1'b1, 3'b000);
        chk("und_p0", out_port0, 32'h1234);
        chk("und_p1", out_port1, 32'h0);
        chk("und_p2", out_port2, 32'h0);
        chk("und_valid", {29'b0, out_valid}, 32'h1);
        rd("und_rd", 32'h90, 32'h0);
        rd("und_stat", 32'h8C, 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
